// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one command-FIFO write port between NUM_REQ producers.
// Words are tagged with the winning channel; admission backs off as the FIFO fills.
module fifo_write_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int PAYLOAD_WIDTH = 6,
  parameter  int PRIO_CH       = 0,
  parameter  int STALL_CNT_W   = 16,
  localparam int TAG_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               enable_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                 ack_o,
  input  logic                               fifo_full_i,
  input  logic                               fifo_almost_full_i,
  output logic                               fifo_wr_en_o,
  output logic [TAG_WIDTH+PAYLOAD_WIDTH-1:0] fifo_wr_data_o,
  output logic [1:0]                         state_o,
  output logic [STALL_CNT_W-1:0]             stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_THROTTLE = 2'b01,
    ST_STALL    = 2'b10
  } state_e;

  localparam logic [NUM_REQ-1:0] PRIO_MASK = {{(NUM_REQ-1){1'b0}}, 1'b1} << PRIO_CH;

  state_e                             state_q, state_d;
  logic [NUM_REQ-1:0]                 ack_q, ack_d;
  logic                               wr_en_q, wr_en_d;
  logic [TAG_WIDTH+PAYLOAD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [TAG_WIDTH-1:0]               rr_q, rr_d;
  logic [STALL_CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic [NUM_REQ-1:0]       req_eff_s;
  logic [NUM_REQ-1:0]       elig_s;
  logic                     grant_vld_s;
  logic [TAG_WIDTH-1:0]     grant_idx_s;
  logic [TAG_WIDTH-1:0]     cand_s;
  logic [PAYLOAD_WIDTH-1:0] data_arr_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr_s[gi] = req_data_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  // A write already in flight while almost full would land the FIFO at full, so stall on it too.
  always_comb begin
    req_eff_s = req_i & ~ack_q;
    if (fifo_full_i || (wr_en_q && fifo_almost_full_i)) begin
      state_d = ST_STALL;
    end else if (fifo_almost_full_i) begin
      state_d = ST_THROTTLE;
    end else begin
      state_d = ST_RUN;
    end
    elig_s = '0;
    if (enable_i) begin
      case (state_d)
        ST_RUN:      elig_s = req_eff_s;
        ST_THROTTLE: elig_s = req_eff_s & PRIO_MASK;
        default:     elig_s = '0;
      endcase
    end else begin
      elig_s = '0;
    end
  end

  // First eligible channel at or above the round-robin pointer, wrapping.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = TAG_WIDTH'((int'(rr_q) + k) % NUM_REQ);
      if (!grant_vld_s && elig_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Next values for the write strobe, tagged word, ack pulse, pointer and stall counter.
  always_comb begin
    ack_d       = '0;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    rr_d        = rr_q;
    stall_cnt_d = stall_cnt_q;
    if (grant_vld_s) begin
      ack_d[grant_idx_s] = 1'b1;
      wr_en_d            = 1'b1;
      wr_data_d          = {grant_idx_s, data_arr_s[grant_idx_s]};
      rr_d               = (grant_idx_s == TAG_WIDTH'(NUM_REQ-1)) ? '0
                                                                  : grant_idx_s + TAG_WIDTH'(1);
    end else if ((req_i != '0) && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and output registers; reset abandons any write in progress.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_RUN;
      ack_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      rr_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rr_q        <= rr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ack_o          = ack_q;
  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_wr_data_o = wr_data_q;
  assign state_o        = state_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter plus a depth-16 FIFO model run with random reads and requests.
module tb_fifo_write_arbiter;
  localparam int NR = 4;
  localparam int PW = 6;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NR-1:0] req;
  logic [NR*PW-1:0] req_data;
  logic [NR-1:0] ack;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_wr_en;
  logic [7:0]    fifo_wr_data;
  logic [1:0]    state;
  logic [SW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] dat [NR];
  logic [PW-1:0] seq_tx [NR];
  logic [PW-1:0] seq_rx [NR];
  logic [7:0]    fq [$];
  logic [7:0]    w;
  int            rd_pct;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ(NR), .PAYLOAD_WIDTH(PW), .PRIO_CH(0), .STALL_CNT_W(SW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .req_i(req), .req_data_i(req_data),
    .ack_o(ack), .fifo_full_i(fifo_full), .fifo_almost_full_i(fifo_almost_full),
    .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data), .state_o(state),
    .stall_cnt_o(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] word(input int ch, input logic [PW-1:0] d);
    logic [1:0] t;
    t = 2'(ch);
    return {t, d};
  endfunction

  initial begin
    reset_n = 1'b0; enable = 1'b1; req = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    dat[0] = 6'h01; dat[1] = 6'h2C; dat[2] = 6'h15; dat[3] = 6'h3A;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_state", state, 0);
    check("rst_stall", stall_cnt, 0);

    // All four channels requesting: rotating tags, one write per cycle
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i*PW +: PW] = dat[i];
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_wr_en", fifo_wr_en, 1);
      check("rr_ack", ack, 32'(4'b0001 << (k % NR)));
      check("rr_data", fifo_wr_data, word(k % NR, dat[k % NR]));
    end
    check("rr_stall", stall_cnt, 0);

    // Lone channel 2: write every other cycle, word 8'h95
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lone_wr_en", fifo_wr_en, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("lone_ack", ack, (k % 2 == 0) ? 32'h4 : 32'h0);
      if (k % 2 == 0) check("lone_data", fifo_wr_data, 32'h95);
    end
    check("lone_stall", stall_cnt, 2);

    // Almost full: only channel 0 admitted
    fifo_almost_full = 1'b1;
    req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("thr_state", state, 1);
      check("thr_wr_en", fifo_wr_en, 0);
      check("thr_stall", stall_cnt, 32'(3 + k));
    end
    req = 4'b1111;
    @(negedge clk);
    check("thr_prio_wr_en", fifo_wr_en, 1);
    check("thr_prio_ack", ack, 1);
    check("thr_prio_data", fifo_wr_data, word(0, dat[0]));
    check("thr_prio_stall", stall_cnt, 5);
    @(negedge clk);
    check("inflight_state", state, 2);
    check("inflight_wr_en", fifo_wr_en, 0);
    check("inflight_stall", stall_cnt, 6);

    // Full FIFO: stall, then write one cycle after full drops
    fifo_almost_full = 1'b0;
    fifo_full = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    check("full_state", state, 2);
    check("full_wr_en", fifo_wr_en, 0);
    check("full_stall", stall_cnt, 7);
    fifo_full = 1'b0;
    @(negedge clk);
    check("unfull_wr_en", fifo_wr_en, 1);
    check("unfull_data", fifo_wr_data, word(0, dat[0]));
    check("unfull_state", state, 0);

    // Asynchronous reset in the middle of a burst
    req = 4'b1111;
    @(negedge clk);
    check("burst_data", fifo_wr_data, word(1, dat[1]));
    #2 reset_n = 1'b0;
    #1;
    check("arst_wr_en", fifo_wr_en, 0);
    check("arst_ack", ack, 0);
    check("arst_stall", stall_cnt, 0);
    check("arst_state", state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack", ack, 1);
    check("post_rst_data", fifo_wr_data, word(0, dat[0]));

    // enable low blocks grants and counts as stalled
    enable = 1'b0;
    @(negedge clk);
    check("dis_wr_en", fifo_wr_en, 0);
    check("dis_stall", stall_cnt, 1);
    enable = 1'b1;
    @(negedge clk);
    check("en_ack", ack, 2);
    check("en_data", fifo_wr_data, word(1, dat[1]));

    // Stall counter saturates at all-ones
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("sat_stall", stall_cnt, 32'h1F);
    check("sat_wr_en", fifo_wr_en, 0);
    enable = 1'b1;

    // Depth-16 FIFO model with random drain and producer traffic
    reset_n = 1'b0;
    req = '0;
    for (int i = 0; i < NR; i++) begin
      seq_tx[i] = '0;
      seq_rx[i] = '0;
      req_data[i*PW +: PW] = '0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd_pct = 30;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      rd_pct = ((cyc / 1000) % 3 == 0) ? 30 : (((cyc / 1000) % 3 == 1) ? 60 : 95);
      check("ack_vs_wr_en", 32'(|ack), 32'(fifo_wr_en));
      if (fifo_wr_en) begin
        check("wr_while_full", fifo_full, 0);
        check("ack_tag", ack, 32'(4'b0001 << fifo_wr_data[7:6]));
      end
      if (fq.size() > 0 && $urandom_range(0, 99) < rd_pct) begin
        w = fq.pop_front();
        check("rx_order", w[5:0], seq_rx[w[7:6]]);
        seq_rx[w[7:6]] = seq_rx[w[7:6]] + 6'd1;
      end
      if (fifo_wr_en && fq.size() < 16) fq.push_back(fifo_wr_data);
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          seq_tx[i] = seq_tx[i] + 6'd1;
          req[i] = ($urandom_range(0, 3) != 0);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
        end
        req_data[i*PW +: PW] = seq_tx[i];
      end
      enable = ($urandom_range(0, 19) != 0);
      fifo_full = (fq.size() == 16);
      fifo_almost_full = (fq.size() >= 14);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
